multicycle_control: RTL and testbench

Moore state machine sequencing the 16-bit multicycle datapath: it steps each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the ALU operand selects, including `OrigBALU` for the B-operand mux, plus ALU op, PC, IR, memory and register-file enables. It sits beside the datapath top and consumes only the IR opcode field and an optional memory-ready handshake.

---
 rtl/mips16_ctrl_pkg.sv | 66 ++++++
 rtl/control_decode.sv | 75 +++++++
 rtl/multicycle_control.sv | 97 +++++++++
 tb/tb_multicycle_control.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_ctrl_pkg.sv
// Shared definitions for the mips16 multicycle controller: state encoding,
// opcode constants and the datapath select encodings used by the muxes.
package mips16_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    R_WB     = 4'd3,
    EXEC_I   = 4'd4,
    I_WB     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_J     = 4'b0111;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] ORIGB_B       = 2'b00;
  localparam logic [1:0] ORIGB_ONE     = 2'b01;
  localparam logic [1:0] ORIGB_IMM     = 2'b10;
  localparam logic [1:0] ORIGB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       origa;
    logic [1:0] origb;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       pcwritecond;
    logic       irwrite;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsource;
    logic       halted;
  } ctrl_t;

  function automatic logic opcode_legal(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: opcode_legal = 1'b1;
      default:                                                 opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational state -> control-word decoder for the multicycle
// controller (Moore outputs; wait gating and Illegal are added by the top).
module control_decode
  import mips16_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.irwrite  = 1'b1;
        ctrl.pcwrite  = 1'b1;
        ctrl.origa    = 1'b0;
        ctrl.origb    = ORIGB_ONE;
        ctrl.aluop    = ALU_ADD;
        ctrl.pcsource = PCSRC_ALU;
      end
      DECODE: begin
        // Speculative branch target into ALUOut while the opcode is examined
        ctrl.origa = 1'b0;
        ctrl.origb = ORIGB_IMM_SH2;
        ctrl.aluop = ALU_ADD;
      end
      EXEC_R: begin
        ctrl.origa = 1'b1;
        ctrl.origb = ORIGB_B;
        ctrl.aluop = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        ctrl.origa = 1'b1;
        ctrl.origb = ORIGB_IMM;
        ctrl.aluop = ALU_ADD;
      end
      I_WB: begin
        ctrl.regwrite = 1'b1;
      end
      MEM_RD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEM_WR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      BRANCH: begin
        ctrl.origa       = 1'b1;
        ctrl.origb       = ORIGB_B;
        ctrl.aluop       = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the 16-bit multicycle datapath. Define MEM_WAIT_EN to
// stretch FETCH/MEM_RD/MEM_WR until MemReady; otherwise MemReady is ignored.
module multicycle_control
  import mips16_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       MemReady,
  output logic       OrigAALU,
  output logic [1:0] OrigBALU,
  output logic [1:0] ALUOp,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [1:0] PCSource,
  output logic       Halted,
  output logic       Illegal
);

  state_t state;
  state_t state_nxt;
  logic   is_store;
  logic   mem_go;
  ctrl_t  ctrl;

`ifdef MEM_WAIT_EN
  assign mem_go = MemReady;
`else
  // Memory always completes in one cycle; the OR keeps the port consumed
  assign mem_go = MemReady | 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // lw/sw distinction is captured in DECODE since opcode is only valid there
  always_ff @(posedge clock) begin
    if (state == DECODE) is_store <= (opcode == OP_SW);
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = mem_go ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt = EXEC_R;
          OP_ADDI:      state_nxt = EXEC_I;
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          OP_HALT:      state_nxt = HALT;
          default:      state_nxt = FETCH;
        endcase
      end
      EXEC_R:   state_nxt = R_WB;
      EXEC_I:   state_nxt = I_WB;
      MEM_ADDR: state_nxt = is_store ? MEM_WR : MEM_RD;
      MEM_RD:   state_nxt = mem_go ? MEM_WB : MEM_RD;
      MEM_WR:   state_nxt = mem_go ? FETCH : MEM_WR;
      HALT:     state_nxt = HALT;
      default:  state_nxt = FETCH;
    endcase
  end

  control_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  // Instruction register and PC only update when the fetch actually returns
  assign IRWrite     = ctrl.irwrite & mem_go;
  assign PCWrite     = ctrl.pcwrite & (mem_go | (state != FETCH));
  assign OrigAALU    = ctrl.origa;
  assign OrigBALU    = ctrl.origb;
  assign ALUOp       = ctrl.aluop;
  assign PCWriteCond = ctrl.pcwritecond;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign IorD        = ctrl.iord;
  assign RegWrite    = ctrl.regwrite;
  assign RegDst      = ctrl.regdst;
  assign MemToReg    = ctrl.memtoreg;
  assign PCSource    = ctrl.pcsource;
  assign Halted      = ctrl.halted;
  assign Illegal     = (state == DECODE) && !opcode_legal(opcode);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control; each cycle the full control
// word is compared against hand-derived per-state values.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       MemReady = 1'b1;
  logic       OrigAALU, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite;
  logic       IorD, RegWrite, RegDst, MemToReg, Halted, Illegal;
  logic [1:0] OrigBALU, ALUOp, PCSource;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .MemReady(MemReady),
    .OrigAALU(OrigAALU), .OrigBALU(OrigBALU), .ALUOp(ALUOp),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .PCSource(PCSource), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 clock = ~clock;

  // {OrigAALU, OrigBALU, ALUOp, PCWrite, PCWriteCond, IRWrite, MemRead,
  //  MemWrite, IorD, RegWrite, RegDst, MemToReg, PCSource, Halted, Illegal}
  logic [17:0] obs;
  assign obs = {OrigAALU, OrigBALU, ALUOp, PCWrite, PCWriteCond, IRWrite, MemRead,
                MemWrite, IorD, RegWrite, RegDst, MemToReg, PCSource, Halted, Illegal};

  localparam logic [17:0] W_FETCH  = 18'b0_01_00_1_0_1_1_0_0_0_0_0_00_0_0;
  localparam logic [17:0] W_FWAIT  = 18'b0_01_00_0_0_0_1_0_0_0_0_0_00_0_0;
  localparam logic [17:0] W_DEC    = 18'b0_11_00_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [17:0] W_DECILL = 18'b0_11_00_0_0_0_0_0_0_0_0_0_00_0_1;
  localparam logic [17:0] W_EXR    = 18'b1_00_10_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [17:0] W_RWB    = 18'b0_00_00_0_0_0_0_0_0_1_1_0_00_0_0;
  localparam logic [17:0] W_EXI    = 18'b1_10_00_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [17:0] W_IWB    = 18'b0_00_00_0_0_0_0_0_0_1_0_0_00_0_0;
  localparam logic [17:0] W_MADDR  = 18'b1_10_00_0_0_0_0_0_0_0_0_0_00_0_0;
  localparam logic [17:0] W_MRD    = 18'b0_00_00_0_0_0_1_0_1_0_0_0_00_0_0;
  localparam logic [17:0] W_MWB    = 18'b0_00_00_0_0_0_0_0_0_1_0_1_00_0_0;
  localparam logic [17:0] W_MWR    = 18'b0_00_00_0_0_0_0_1_1_0_0_0_00_0_0;
  localparam logic [17:0] W_BR     = 18'b1_00_01_0_1_0_0_0_0_0_0_0_01_0_0;
  localparam logic [17:0] W_JMP    = 18'b0_00_00_1_0_0_0_0_0_0_0_0_10_0_0;
  localparam logic [17:0] W_HALT   = 18'b0_00_00_0_0_0_0_0_0_0_0_0_00_1_0;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++;
    if (obs !== W_FETCH) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, W_FETCH);
    end
    checks++;
    if ({Halted, Illegal} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got %b want 00", {Halted, Illegal});
    end
  endtask

  task automatic test_rtype_addi();
    logic [3:0]  op [10];
    logic [17:0] w  [10];
    op = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
    w  = '{W_FETCH, W_DEC, W_EXR, W_RWB, W_FETCH, W_DEC, W_EXI, W_IWB, W_FETCH, W_DEC};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      opcode = op[i];
      #1;
      checks++;
      if (obs !== w[i]) begin
        errors++;
        $display("FAIL rtype_addi cyc%0d got %b want %b", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_lw_sw();
    // opcode flips in MEM_ADDR are ignored: only DECODE samples it
    logic [3:0]  op [10];
    logic [17:0] w  [10];
    op = '{4'h4, 4'h4, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h4, 4'h0, 4'h0};
    w  = '{W_FETCH, W_DEC, W_MADDR, W_MRD, W_MWB, W_FETCH, W_DEC, W_MADDR, W_MWR, W_FETCH};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      opcode = op[i];
      #1;
      checks++;
      if (obs !== w[i]) begin
        errors++;
        $display("FAIL lw_sw cyc%0d got %b want %b", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    logic [3:0]  op [7];
    logic [17:0] w  [7];
    op = '{4'h6, 4'h6, 4'h7, 4'h7, 4'h7, 4'h7, 4'h0};
    w  = '{W_FETCH, W_DEC, W_BR, W_FETCH, W_DEC, W_JMP, W_FETCH};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      opcode = op[i];
      #1;
      checks++;
      if (obs !== w[i]) begin
        errors++;
        $display("FAIL branch_jump cyc%0d got %b want %b", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  op [5];
    logic [17:0] w  [5];
    op = '{4'h9, 4'h9, 4'h9, 4'h3, 4'h0};
    w  = '{W_FETCH, W_DECILL, W_FETCH, W_DECILL, W_FETCH};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      opcode = op[i];
      #1;
      checks++;
      if (obs !== w[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d got %b want %b", i, obs, w[i]);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    @(negedge clock);
    opcode = 4'hF;
    @(negedge clock);
    #1;
    checks++;
    if (obs !== W_DEC) begin
      errors++;
      $display("FAIL halt_decode got %b want %b", obs, W_DEC);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      opcode = 4'(i);
      #1;
      checks++;
      if (obs !== W_HALT) begin
        errors++;
        $display("FAIL halt_hold cyc%0d got %b want %b", i, obs, W_HALT);
      end
    end
    do_reset();
    @(negedge clock);
    checks++;
    if (obs !== W_FETCH) begin
      errors++;
      $display("FAIL halt_reset got %b want %b", obs, W_FETCH);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 4'h0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (obs !== W_EXR) begin
      errors++;
      $display("FAIL mid_exec_r got %b want %b", obs, W_EXR);
    end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (obs !== W_FETCH) begin
      errors++;
      $display("FAIL mid_reset got %b want %b", obs, W_FETCH);
    end
  endtask

  task automatic test_memready();
`ifdef MEM_WAIT_EN
    logic        rdy [9];
    logic [17:0] w   [9];
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    w   = '{W_FWAIT, W_FWAIT, W_FWAIT, W_FETCH, W_DEC, W_MADDR, W_MRD, W_MWB, W_FETCH};
`else
    logic        rdy [6];
    logic [17:0] w   [6];
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    w   = '{W_FETCH, W_DEC, W_MADDR, W_MRD, W_MWB, W_FETCH};
`endif
    do_reset();
    opcode = 4'h4;
    for (int i = 0; i < $size(w); i++) begin
      @(negedge clock);
      MemReady = rdy[i];
      #1;
      checks++;
      if (obs !== w[i]) begin
        errors++;
        $display("FAIL memready cyc%0d got %b want %b", i, obs, w[i]);
      end
    end
    MemReady = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype_addi();
    test_lw_sw();
    test_branch_jump();
    test_illegal();
    test_halt();
    test_reset_mid();
    test_memready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
